uart_tx_framer: RTL and testbench
=================================

# uart_tx_framer

Serial transmit framer for the USB3300 parser's host-side UART link. It accepts parsed bytes over a valid/ready handshake and serialises them LSB-first onto `tx` as start/data/optional-parity/stop frames. Bit timing comes from the downstream-facing baud generator (`clk_gen`): this block drives that generator's `enable` and advances one bit per `baud_tick` pulse. A one-word holding register allows back-to-back frames with no idle gap.

## Interface
- `DATA_BITS`, default 8: data bits per frame, range 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk`.
- `data`  in  DATA_BITS  word to transmit.
- `data_valid`  in  1  `data` is presented.
- `data_ready`  out  1  holding register empty; a word is accepted when `data_valid && data_ready`.
- `baud_tick`  in  1  one-`clk` pulse per bit period from `clk_gen`.
- `baud_en`  out  1  drives `clk_gen` `enable`. The generator counter clears while this is low.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from word acceptance until the last stop bit completes with nothing pending.

## Operation
- **Reset values** (registered outputs): `tx`=1, `baud_en`=0, `busy`=0, `data_ready`=1, FSM in IDLE, holding register empty. Accepts are ignored while `rst_n`=0.
- **Holding register:** loaded on an accept; `data_ready` falls the next cycle. The register empties when the shifter loads from it; `data_ready` rises the next cycle.
- **FSM states:**
  - IDLE: `tx`=1, `baud_en`=0. If the holding register is full, move to SYNC and assert `baud_en`.
  - SYNC: waits for the first `baud_tick`. This absorbs the generator's unaligned first period. On the tick, load the shifter from the holding register, set `tx`=0, and go to START.
  - START: on tick, `tx`=data bit 0, bit counter = 1, go to DATA.
  - DATA: on each tick, output the next bit. After bit DATA_BITS-1 has been held for one period, the next tick drives the parity bit (go to PARITY) if PARITY≠0, otherwise stop bit 1 (go to STOP).
  - PARITY: parity bit = XOR of the data bits, inverted for odd parity. On tick, `tx`=1, go to STOP.
  - STOP: holds STOP_BITS periods. On the tick ending the last stop bit:
    - If the holding register is full, load the shifter, set `tx`=0, and go to START with `baud_en` kept high (zero gap).
    - Otherwise go to IDLE and drop `baud_en`.
- **Counters:** bit counter width is clog2(DATA_BITS+1) and is compared exactly, with no wrap. Stop counter is 1 bit.
- **Simultaneous events:**
  - An accept on the same cycle the shifter loads from the holding register is legal only if `data_ready` was already high. The holding register never overwrites unsent data.
  - A `baud_tick` while in IDLE is ignored.
- **Reset mid-frame:** the line returns to `tx`=1 the next cycle, and both the pending word and the in-flight word are discarded.
- **`busy`:** equals (FSM≠IDLE) OR (holding register full), registered.

## Timing
- Accept to `baud_en` high: 2 cycles (accept, register full, IDLE→SYNC).
- `tx` changes exactly 1 `clk` after each consumed `baud_tick`.
- Every bit lasts exactly one tick-to-tick interval, including the start bit.
- Frame length is 1+DATA_BITS+(PARITY≠0)+STOP_BITS ticks after SYNC.
- `baud_en` falls 1 cycle after the final stop tick when idle.
- `data_valid` may stay high across frames. `data` must be stable while `data_valid && !data_ready`.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encoding (IDLE, SYNC, START, DATA, PARITY, STOP);
  - PARITY constants NONE/ODD/EVEN;
  - a frame-length function.
- One sub-module is natural: `uart_tx_hold`, the one-word holding register with its valid/ready handshake, reusable by the RX-side response path.
- `clk_gen` is instantiated by the parent, not inside this block.

## Test plan
The bench uses `clk_gen` with DIVIDER=4, giving a 16-cycle tick period.
- **Single byte:** 8N1, send 0x55 → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each level 16 cycles; `baud_en` low afterwards; `busy` low 1 cycle after the stop tick.
- **Even parity:** PARITY=2, send 0x55 → parity bit 0. PARITY=2, send 0x07 → parity bit 1. PARITY=1, send 0x07 → parity bit 0.
- **Back-to-back:** `data_valid` held high with 0xA5 then 0x3C → no idle period between stop and start; `baud_en` stays high throughout; `data_ready` rises once the shifter loads 0xA5.
- **Handshake stall:** offer 0x11, 0x22, 0x33 in consecutive cycles → 0x22 is accepted only after 0x11 leaves the holding register; 0x33 waits; all three are transmitted in order, unmodified.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 3 → `tx`=1, `baud_en`=0, `data_ready`=1 one cycle later; no residual bits after release.
- **Config sweep:** DATA_BITS=7 with STOP_BITS=2, send 0x7F → 11 ticks per frame; both stop bits high for 32 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared UART types, parity selectors and frame-length helper.
// Revision 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  localparam int unsigned C_PARITY_NONE = 0;
  localparam int unsigned C_PARITY_ODD  = 1;
  localparam int unsigned C_PARITY_EVEN = 2;

  // Bit periods in one frame, start bit through last stop bit.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned parity,
                                            input int unsigned stop_bits);
    return 1 + data_bits + ((parity != C_PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_hold.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_hold : one-word holding register with valid/ready input handshake.
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             pop,
  output logic             full,
  output logic             full_next,
  output logic [WIDTH-1:0] out_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             accept;

  // Accepts only into an empty register, so a pop and an accept never collide.
  always_comb begin
    accept = in_valid && !full_q;
    full_d = full_q;
    word_d = word_q;
    if (accept) begin
      full_d = 1'b1;
      word_d = in_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
    end
  end

  assign in_ready  = !full_q;
  assign full      = full_q;
  assign full_next = full_d;
  assign out_data  = word_q;

endmodule
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_framer : LSB-first UART framer paced by an external baud tick.
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = C_PARITY_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned          CNT_W       = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]     C_LAST_BIT  = CNT_W'(DATA_BITS);
  localparam logic                 C_LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 baud_en_q, baud_en_d;
  logic                 busy_q, busy_d;

  logic [DATA_BITS-1:0] hold_word;
  logic                 hold_full, hold_full_next, hold_pop;
  logic                 parity_in, last_bit, last_stop, load;

  uart_tx_hold #(.WIDTH(DATA_BITS)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (data),
    .in_valid  (data_valid),
    .in_ready  (data_ready),
    .pop       (hold_pop),
    .full      (hold_full),
    .full_next (hold_full_next),
    .out_data  (hold_word)
  );

  if (PARITY == C_PARITY_ODD) begin : g_parity_odd
    assign parity_in = ~^hold_word;
  end else if (PARITY == C_PARITY_EVEN) begin : g_parity_even
    assign parity_in = ^hold_word;
  end else begin : g_parity_none
    assign parity_in = 1'b0;
  end

  assign last_bit  = (bit_cnt_q == C_LAST_BIT);
  assign last_stop = (stop_cnt_q == C_LAST_STOP);
  // Shifter loads on the SYNC tick, or back-to-back at the end of the last stop bit.
  assign load      = baud_tick && (((state_q == ST_SYNC)) ||
                                   ((state_q == ST_STOP) && last_stop && hold_full));
  assign hold_pop  = load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (hold_full) state_d = ST_SYNC;
      ST_SYNC:   if (baud_tick) state_d = ST_START;
      ST_START:  if (baud_tick) state_d = ST_DATA;
      ST_DATA:   if (baud_tick && last_bit)
                   state_d = (PARITY != C_PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_tick) state_d = ST_STOP;
      ST_STOP:   if (baud_tick && last_stop)
                   state_d = hold_full ? ST_START : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    baud_en_d  = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE) || hold_full_next;
    if (load) begin
      shift_d  = hold_word;
      parity_d = parity_in;
      tx_d     = 1'b0;
    end else if (baud_tick) begin
      case (state_q)
        ST_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = CNT_W'(1);
        end
        ST_DATA: begin
          if (last_bit) begin
            tx_d       = (PARITY != C_PARITY_NONE) ? parity_q : 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        ST_STOP: begin
          tx_d       = 1'b1;
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      baud_en_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      baud_en_q  <= baud_en_d;
      busy_q     <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign baud_en = baud_en_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_framer : four framer configurations checked against a line decoder.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_framer;

  localparam int NI    = 4;
  localparam int BOUND = 4000;
  localparam int NB  [NI] = '{8, 8, 8, 7};
  localparam int PAR [NI] = '{0, 2, 1, 0};
  localparam int NS  [NI] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0]    data_8 [3];
  logic [6:0]    data_7;
  logic [NI-1:0] valid_v, ready_v, tick_v, en_v, tx_v, busy_v;
  logic [3:0]    bcnt [NI];
  logic [NI-1:0] seen_v  = '0;
  logic [NI-1:0] en_prev = '0;
  int cyc = 0;
  int tick_tot  [NI] = '{default: 0};
  int en_rise   [NI] = '{default: 0};
  int last_tick [NI] = '{default: 0};
  int sync_tick [NI] = '{default: 0};
  logic [7:0] exp_q [NI][$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx_framer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_8n1 (
    .clk(clk), .rst_n(rst_n), .data(data_8[0]), .data_valid(valid_v[0]),
    .data_ready(ready_v[0]), .baud_tick(tick_v[0]), .baud_en(en_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_8e1 (
    .clk(clk), .rst_n(rst_n), .data(data_8[1]), .data_valid(valid_v[1]),
    .data_ready(ready_v[1]), .baud_tick(tick_v[1]), .baud_en(en_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]));
  uart_tx_framer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut_8o1 (
    .clk(clk), .rst_n(rst_n), .data(data_8[2]), .data_valid(valid_v[2]),
    .data_ready(ready_v[2]), .baud_tick(tick_v[2]), .baud_en(en_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]));
  uart_tx_framer #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut_7n2 (
    .clk(clk), .rst_n(rst_n), .data(data_7), .data_valid(valid_v[3]),
    .data_ready(ready_v[3]), .baud_tick(tick_v[3]), .baud_en(en_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]));

  // Baud generator stand-in: counter clears while disabled, one tick every 16 clocks.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NI; k++) bcnt[k] <= en_v[k] ? bcnt[k] + 4'd1 : 4'd0;
  end

  always_comb begin
    for (int k = 0; k < NI; k++) tick_v[k] = en_v[k] && (bcnt[k] == 4'd15);
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      en_prev[k] <= en_v[k];
      if (en_v[k] && !en_prev[k]) en_rise[k] <= en_rise[k] + 1;
      if (tick_v[k]) begin
        tick_tot[k]  <= tick_tot[k] + 1;
        last_tick[k] <= cyc;
        if (!seen_v[k]) sync_tick[k] <= cyc;
      end
      seen_v[k] <= en_v[k] && (seen_v[k] || tick_v[k]);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int flen(input int k);
    return 1 + NB[k] + ((PAR[k] != 0) ? 1 : 0) + NS[k];
  endfunction

  // Line decoder: samples every clock of the frame, so each level must last 16 clocks.
  task automatic rx_monitor(input int k);
    int         total;
    logic       lvl [16];
    logic       stable, aborted;
    logic [7:0] word, want;
    logic       par_exp;
    total = flen(k);
    forever begin
      do @(negedge clk); while (tx_v[k] !== 1'b0 || rst_n !== 1'b1);
      stable  = 1'b1;
      aborted = 1'b0;
      for (int i = 0; i < total * 16; i++) begin
        if (i > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (i % 16 == 0) lvl[i / 16] = tx_v[k];
        else if (tx_v[k] !== lvl[i / 16]) stable = 1'b0;
      end
      if (!aborted) begin
        word = '0;
        for (int b = 0; b < NB[k]; b++) word[b] = lvl[1 + b];
        check_eq($sformatf("u%0d_start_bit", k), 32'(lvl[0]), 0);
        check_eq($sformatf("u%0d_bit_width", k), 32'(stable), 1);
        check_eq($sformatf("u%0d_frame_expected", k), 32'(exp_q[k].size() != 0), 1);
        if (exp_q[k].size() != 0) begin
          want = exp_q[k].pop_front();
          check_eq($sformatf("u%0d_data", k), 32'(word), 32'(want));
          if (PAR[k] != 0) begin
            par_exp = (($countones(want) % 2) == 1) ^ (PAR[k] == 1);
            check_eq($sformatf("u%0d_parity", k), 32'(lvl[1 + NB[k]]), 32'(par_exp));
          end
        end
        for (int s = 0; s < NS[k]; s++)
          check_eq($sformatf("u%0d_stop%0d", k, s), 32'(lvl[total - 1 - s]), 1);
      end
    end
  endtask

  task automatic send(input int k, input logic [7:0] w, output int acc);
    int n = 0;
    if (k == 3) data_7 = w[6:0];
    else data_8[k] = w;
    valid_v[k] = 1'b1;
    while (ready_v[k] !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("u%0d_ready_wait", k), 32'(n < BOUND), 1);
    acc = cyc;
    if (n < BOUND) exp_q[k].push_back((k == 3) ? {1'b0, w[6:0]} : w);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int k, input int ticks0, input int rises0, input int exp_ticks);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_v[k] !== 1'b0 && n < BOUND);
    check_eq($sformatf("u%0d_idle_wait", k), 32'(n < BOUND), 1);
    check_eq($sformatf("u%0d_baud_en_off", k), 32'(en_v[k]), 0);
    check_eq($sformatf("u%0d_busy_lag", k), 32'(cyc - last_tick[k]), 1);
    check_eq($sformatf("u%0d_tick_count", k), 32'(tick_tot[k] - ticks0), 32'(exp_ticks));
    check_eq($sformatf("u%0d_baud_en_rises", k), 32'(en_rise[k] - rises0), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, a1, a2, a3, tsync, n, bad, nw;
    rst_n   = 1'b0;
    valid_v = '0;
    data_8  = '{default: 8'h00};
    data_7  = '0;
    fork
      rx_monitor(0);
      rx_monitor(1);
      rx_monitor(2);
      rx_monitor(3);
    join_none

    // Reset values, with an offered word that must be ignored.
    repeat (3) @(negedge clk);
    valid_v[0] = 1'b1;
    data_8[0]  = 8'hFF;
    @(negedge clk);
    check_eq("rst_ready", 32'(ready_v[0]), 1);
    check_eq("rst_busy", 32'(busy_v[0]), 0);
    check_eq("rst_tx", 32'(tx_v), 32'hF);
    check_eq("rst_baud_en", 32'(en_v), 0);
    valid_v[0] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(busy_v[0]), 0);

    // Single 8N1 byte: handshake and enable latency, then a full frame.
    t0 = tick_tot[0]; r0 = en_rise[0];
    send(0, 8'h55, a1);
    valid_v[0] = 1'b0;
    check_eq("acc_ready_low", 32'(ready_v[0]), 0);
    check_eq("acc_busy_high", 32'(busy_v[0]), 1);
    check_eq("acc_baud_en_low", 32'(en_v[0]), 0);
    @(negedge clk);
    check_eq("acc_baud_en_high", 32'(en_v[0]), 1);
    wait_idle(0, t0, r0, 1 + flen(0));

    // Parity variants.
    t0 = tick_tot[1]; r0 = en_rise[1];
    send(1, 8'h55, a1); valid_v[1] = 1'b0;
    wait_idle(1, t0, r0, 1 + flen(1));
    t0 = tick_tot[1]; r0 = en_rise[1];
    send(1, 8'h07, a1); valid_v[1] = 1'b0;
    wait_idle(1, t0, r0, 1 + flen(1));
    t0 = tick_tot[2]; r0 = en_rise[2];
    send(2, 8'h07, a1); valid_v[2] = 1'b0;
    wait_idle(2, t0, r0, 1 + flen(2));

    // Back-to-back with data_valid held.
    t0 = tick_tot[0]; r0 = en_rise[0];
    send(0, 8'hA5, a1);
    send(0, 8'h3C, a2);
    valid_v[0] = 1'b0;
    check_eq("b2b_ready_rise", 32'(a2 - sync_tick[0]), 1);
    wait_idle(0, t0, r0, 1 + 2 * flen(0));

    // Handshake stall across three words.
    t0 = tick_tot[0]; r0 = en_rise[0];
    send(0, 8'h11, a1);
    send(0, 8'h22, a2);
    send(0, 8'h33, a3);
    valid_v[0] = 1'b0;
    check_eq("stall_second_accept", 32'(a2 - sync_tick[0]), 1);
    check_eq("stall_third_accept", 32'(a3 - a2), 32'(16 * flen(0)));
    wait_idle(0, t0, r0, 1 + 3 * flen(0));

    // Reset during data bit 3 with a second word pending.
    send(0, 8'($urandom), a1);
    send(0, 8'($urandom), a2);
    valid_v[0] = 1'b0;
    tsync = sync_tick[0];
    n = 0;
    while (cyc < tsync + 70 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_tx", 32'(tx_v[0]), 1);
    check_eq("midrst_baud_en", 32'(en_v[0]), 0);
    check_eq("midrst_ready", 32'(ready_v[0]), 1);
    check_eq("midrst_busy", 32'(busy_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q[0].delete();
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || en_v[0] !== 1'b0) bad++;
    end
    check_eq("midrst_no_residual", 32'(bad), 0);

    // 7N2 sweep.
    t0 = tick_tot[3]; r0 = en_rise[3];
    send(3, 8'h7F, a1); valid_v[3] = 1'b0;
    wait_idle(3, t0, r0, 1 + flen(3));

    // Randomised bursts on every configuration.
    for (int k = 0; k < NI; k++) begin
      repeat (5) begin
        repeat ($urandom_range(0, 30)) @(negedge clk);
        nw = $urandom_range(1, 3);
        t0 = tick_tot[k]; r0 = en_rise[k];
        for (int j = 0; j < nw; j++) send(k, 8'($urandom), a1);
        valid_v[k] = 1'b0;
        wait_idle(k, t0, r0, 1 + nw * flen(k));
      end
    end

    repeat (20) @(negedge clk);
    for (int k = 0; k < NI; k++)
      check_eq($sformatf("u%0d_drained", k), 32'(exp_q[k].size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
